// File: rtl/fetch_unit.sv
// Purpose : instruction fetch stage; issues a req/ack word read for an aligned PC and latches the result into IR.
// Latency : fetch_start to ir_valid is 2 cycles with a zero-wait ack, plus 1 cycle per wait state; timeout after TIMEOUT req cycles.
// Backpr. : a single fetch is in flight at a time; fetch_start outside IDLE is dropped, never queued; flush aborts immediately.
//
// Ports:
//   i_clka, i_reset              clock, async active-low reset
//   i_fetch_start, i_pc_in       fetch command and byte address (bit 0 must be 0)
//   i_flush                      abort fetch, invalidate IR
//   o_mem_req, o_mem_addr        read request and word address to instruction memory
//   i_mem_rdata, i_mem_ack       read data and acknowledge
//   o_ir_out, o_ir_valid         instruction register and its valid flag
//   o_opcode, o_imm_out          decoded fields of IR
//   o_fetch_busy, o_fetch_err    request in progress / one-cycle error pulse
module fetch_unit #(
  parameter int PC_BITS    = 6,
  parameter int INSTR_BITS = 16,
  parameter int TIMEOUT    = 15
) (
  input  logic                  i_clka,
  input  logic                  i_reset,
  input  logic                  i_fetch_start,
  input  logic                  i_flush,
  input  logic [PC_BITS-1:0]    i_pc_in,
  output logic                  o_mem_req,
  output logic [PC_BITS-2:0]    o_mem_addr,
  input  logic [INSTR_BITS-1:0] i_mem_rdata,
  input  logic                  i_mem_ack,
  output logic [INSTR_BITS-1:0] o_ir_out,
  output logic                  o_ir_valid,
  output logic [3:0]            o_opcode,
  output logic [PC_BITS-1:0]    o_imm_out,
  output logic                  o_fetch_busy,
  output logic                  o_fetch_err
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [PC_BITS-2:0]    r_mem_addr;
  logic [INSTR_BITS-1:0] r_ir;
  logic                  r_ir_valid;
  logic [CW-1:0]         r_cnt;

  logic w_load_addr;
  logic w_load_ir;
  logic w_set_valid;
  logic w_clr_valid;
  logic w_cnt_clr;
  logic w_cnt_inc;

  always_ff @(posedge i_clka or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_load_addr = 1'b0;
    w_load_ir   = 1'b0;
    w_set_valid = 1'b0;
    w_clr_valid = 1'b0;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    if (i_flush) begin
      // Flush beats ack, start and timeout alike; no error pulse.
      w_next      = S_IDLE;
      w_clr_valid = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_fetch_start) begin
            if (i_pc_in[0]) begin
              // Misaligned: error only, IR and its valid flag untouched.
              w_next = S_ERR;
            end else begin
              w_next      = S_REQ;
              w_load_addr = 1'b1;
              w_cnt_clr   = 1'b1;
              w_clr_valid = 1'b1;
            end
          end
        end
        S_REQ: begin
          // Ack is checked first so a last-cycle ack still completes.
          if (i_mem_ack) begin
            w_next      = S_IDLE;
            w_load_ir   = 1'b1;
            w_set_valid = 1'b1;
          end else if (r_cnt == CNT_LAST) begin
            w_next = S_ERR;
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
        S_ERR:   w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clka or negedge i_reset) begin
    if (!i_reset) begin
      r_mem_addr <= '0;
      r_ir       <= '0;
      r_ir_valid <= 1'b0;
      r_cnt      <= '0;
    end else begin
      if (w_load_addr) r_mem_addr <= i_pc_in[PC_BITS-1:1];
      if (w_load_ir)   r_ir       <= i_mem_rdata;
      if (w_cnt_clr)        r_cnt <= '0;
      else if (w_cnt_inc)   r_cnt <= r_cnt + 1'b1;
      if (w_clr_valid)      r_ir_valid <= 1'b0;
      else if (w_set_valid) r_ir_valid <= 1'b1;
    end
  end

  // Control outputs are pure decodes of the state register.
  assign o_mem_req    = (r_state == S_REQ);
  assign o_fetch_busy = (r_state == S_REQ);
  assign o_fetch_err  = (r_state == S_ERR);
  assign o_mem_addr   = r_mem_addr;
  assign o_ir_out     = r_ir;
  assign o_ir_valid   = r_ir_valid;
  assign o_opcode     = r_ir[INSTR_BITS-1 -: 4];
  assign o_imm_out    = r_ir[PC_BITS-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clka;
  logic        reset;
  logic        fetch_start;
  logic        flush;
  logic [5:0]  pc_in;
  logic        mem_req;
  logic [4:0]  mem_addr;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic [15:0] ir_out;
  logic        ir_valid;
  logic [3:0]  opcode;
  logic [5:0]  imm_out;
  logic        fetch_busy;
  logic        fetch_err;

  int total = 0;
  int bad   = 0;

  fetch_unit #(.PC_BITS(6), .INSTR_BITS(16), .TIMEOUT(15)) dut (
    .i_clka        (clka),
    .i_reset       (reset),
    .i_fetch_start (fetch_start),
    .i_flush       (flush),
    .i_pc_in       (pc_in),
    .o_mem_req     (mem_req),
    .o_mem_addr    (mem_addr),
    .i_mem_rdata   (mem_rdata),
    .i_mem_ack     (mem_ack),
    .o_ir_out      (ir_out),
    .o_ir_valid    (ir_valid),
    .o_opcode      (opcode),
    .o_imm_out     (imm_out),
    .o_fetch_busy  (fetch_busy),
    .o_fetch_err   (fetch_err)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  // Advance one rising edge; inputs are driven and outputs sampled on the falling edge.
  task automatic tick();
    @(posedge clka);
    @(negedge clka);
  endtask

  task automatic test_reset();
    // Power-on reset state.
    total++; if ({mem_req, mem_addr, ir_out, ir_valid, fetch_busy, fetch_err, opcode, imm_out} !== '0) begin
      bad++; $display("FAIL por_outputs got req=%b addr=%h ir=%h v=%b busy=%b err=%b exp all 0", mem_req, mem_addr, ir_out, ir_valid, fetch_busy, fetch_err); end
    reset = 1'b1;
    tick();
    // Start a fetch and reset it asynchronously mid-REQ.
    pc_in = 6'h0A; fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    total++; if (mem_req !== 1'b1 || ir_valid !== 1'b0) begin
      bad++; $display("FAIL pre_reset_req got req=%b v=%b exp req=1 v=0", mem_req, ir_valid); end
    #2 reset = 1'b0;
    #1;
    total++; if ({mem_req, mem_addr, ir_out, ir_valid, fetch_busy, fetch_err, opcode, imm_out} !== '0) begin
      bad++; $display("FAIL async_reset got req=%b addr=%h ir=%h v=%b busy=%b err=%b exp all 0", mem_req, mem_addr, ir_out, ir_valid, fetch_busy, fetch_err); end
    @(negedge clka);
    reset = 1'b1;
    tick();
    total++; if ({mem_req, mem_addr, ir_out, ir_valid, fetch_busy, fetch_err} !== '0) begin
      bad++; $display("FAIL post_reset_idle got req=%b addr=%h ir=%h v=%b busy=%b err=%b exp all 0", mem_req, mem_addr, ir_out, ir_valid, fetch_busy, fetch_err); end
  endtask

  task automatic test_zero_wait();
    pc_in = 6'h0A; fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    total++; if (mem_req !== 1'b1 || fetch_busy !== 1'b1 || mem_addr !== 5'h05 || ir_valid !== 1'b0) begin
      bad++; $display("FAIL zw_req got req=%b busy=%b addr=%h v=%b exp 1 1 05 0", mem_req, fetch_busy, mem_addr, ir_valid); end
    mem_ack = 1'b1; mem_rdata = 16'h5A3C;
    tick();
    mem_ack = 1'b0;
    total++; if (ir_out !== 16'h5A3C || opcode !== 4'h5 || imm_out !== 6'h3C || ir_valid !== 1'b1) begin
      bad++; $display("FAIL zw_ir got ir=%h op=%h imm=%h v=%b exp 5a3c 5 3c 1", ir_out, opcode, imm_out, ir_valid); end
    total++; if (mem_req !== 1'b0 || fetch_busy !== 1'b0 || fetch_err !== 1'b0) begin
      bad++; $display("FAIL zw_done got req=%b busy=%b err=%b exp 0 0 0", mem_req, fetch_busy, fetch_err); end
  endtask

  task automatic test_wait_states();
    int req_cycles = 0;
    int busy_bad   = 0;
    pc_in = 6'h3E; fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    for (int i = 0; i < 8 && mem_req === 1'b1; i++) begin
      req_cycles++;
      if (fetch_busy !== 1'b1 || mem_addr !== 5'h1F) busy_bad++;
      mem_ack = (i == 3); mem_rdata = 16'hF001;
      tick();
    end
    mem_ack = 1'b0;
    total++; if (req_cycles !== 4) begin
      bad++; $display("FAIL ws_req_cycles got %0d exp 4", req_cycles); end
    total++; if (busy_bad !== 0) begin
      bad++; $display("FAIL ws_busy_addr got %0d bad cycles exp 0", busy_bad); end
    total++; if (ir_out !== 16'hF001 || ir_valid !== 1'b1 || mem_addr !== 5'h1F) begin
      bad++; $display("FAIL ws_ir got ir=%h v=%b addr=%h exp f001 1 1f", ir_out, ir_valid, mem_addr); end
  endtask

  task automatic test_misaligned();
    pc_in = 6'h07; fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    total++; if (fetch_err !== 1'b1 || mem_req !== 1'b0) begin
      bad++; $display("FAIL mis_pulse got err=%b req=%b exp 1 0", fetch_err, mem_req); end
    tick();
    total++; if (fetch_err !== 1'b0 || mem_req !== 1'b0) begin
      bad++; $display("FAIL mis_after got err=%b req=%b exp 0 0", fetch_err, mem_req); end
    total++; if (ir_out !== 16'hF001 || ir_valid !== 1'b1 || mem_addr !== 5'h1F) begin
      bad++; $display("FAIL mis_keep got ir=%h v=%b addr=%h exp f001 1 1f", ir_out, ir_valid, mem_addr); end
  endtask

  task automatic test_timeout();
    int req_cycles = 0;
    int err_early  = 0;
    pc_in = 6'h10; fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    for (int i = 0; i < 40 && mem_req === 1'b1; i++) begin
      req_cycles++;
      if (fetch_err !== 1'b0) err_early++;
      tick();
    end
    total++; if (req_cycles !== 15 || err_early !== 0) begin
      bad++; $display("FAIL to_req_cycles got %0d (early err %0d) exp 15 (0)", req_cycles, err_early); end
    total++; if (fetch_err !== 1'b1 || ir_valid !== 1'b0 || ir_out !== 16'hF001) begin
      bad++; $display("FAIL to_err got err=%b v=%b ir=%h exp 1 0 f001", fetch_err, ir_valid, ir_out); end
    tick();
    total++; if (fetch_err !== 1'b0 || mem_req !== 1'b0) begin
      bad++; $display("FAIL to_err_width got err=%b req=%b exp 0 0", fetch_err, mem_req); end
    // Ack on the last allowed cycle wins over the timeout.
    req_cycles = 0;
    pc_in = 6'h12; fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    for (int i = 0; i < 40 && mem_req === 1'b1; i++) begin
      req_cycles++;
      mem_ack = (i == 14); mem_rdata = 16'h1234;
      tick();
    end
    mem_ack = 1'b0;
    total++; if (req_cycles !== 15 || ir_out !== 16'h1234 || ir_valid !== 1'b1 || fetch_err !== 1'b0) begin
      bad++; $display("FAIL to_last_ack got cyc=%0d ir=%h v=%b err=%b exp 15 1234 1 0", req_cycles, ir_out, ir_valid, fetch_err); end
    tick();
    total++; if (fetch_err !== 1'b0 || mem_addr !== 5'h09) begin
      bad++; $display("FAIL to_last_ack_after got err=%b addr=%h exp 0 09", fetch_err, mem_addr); end
  endtask

  task automatic test_flush();
    pc_in = 6'h20; fetch_start = 1'b1;
    tick();
    // A second start while in REQ must be dropped.
    pc_in = 6'h30; fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    total++; if (mem_req !== 1'b1 || mem_addr !== 5'h10) begin
      bad++; $display("FAIL fl_ignored_start got req=%b addr=%h exp 1 10", mem_req, mem_addr); end
    flush = 1'b1; mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    tick();
    flush = 1'b0; mem_ack = 1'b0;
    total++; if (mem_req !== 1'b0 || fetch_busy !== 1'b0 || fetch_err !== 1'b0) begin
      bad++; $display("FAIL fl_abort got req=%b busy=%b err=%b exp 0 0 0", mem_req, fetch_busy, fetch_err); end
    total++; if (ir_out !== 16'h1234 || ir_valid !== 1'b0) begin
      bad++; $display("FAIL fl_ir got ir=%h v=%b exp 1234 0", ir_out, ir_valid); end
    tick();
    total++; if (mem_req !== 1'b0 || fetch_err !== 1'b0 || mem_addr !== 5'h10) begin
      bad++; $display("FAIL fl_idle got req=%b err=%b addr=%h exp 0 0 10", mem_req, fetch_err, mem_addr); end
  endtask

  task automatic test_back_to_back();
    pc_in = 6'h04; fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0; mem_ack = 1'b1; mem_rdata = 16'h7777;
    tick();
    mem_ack = 1'b0;
    total++; if (ir_valid !== 1'b1 || ir_out !== 16'h7777 || mem_addr !== 5'h02) begin
      bad++; $display("FAIL b2b_first got v=%b ir=%h addr=%h exp 1 7777 02", ir_valid, ir_out, mem_addr); end
    // Start the next fetch in the same cycle ir_valid first reads 1.
    pc_in = 6'h08; fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    total++; if (ir_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 5'h04) begin
      bad++; $display("FAIL b2b_accept got v=%b req=%b addr=%h exp 0 1 04", ir_valid, mem_req, mem_addr); end
    mem_ack = 1'b1; mem_rdata = 16'h0ABC;
    tick();
    mem_ack = 1'b0;
    total++; if (ir_out !== 16'h0ABC || ir_valid !== 1'b1 || opcode !== 4'h0 || imm_out !== 6'h3C) begin
      bad++; $display("FAIL b2b_second got ir=%h v=%b op=%h imm=%h exp 0abc 1 0 3c", ir_out, ir_valid, opcode, imm_out); end
    // Ack outside REQ is ignored.
    mem_ack = 1'b1; mem_rdata = 16'hFFFF;
    tick();
    mem_ack = 1'b0;
    total++; if (ir_out !== 16'h0ABC || ir_valid !== 1'b1 || mem_req !== 1'b0) begin
      bad++; $display("FAIL stray_ack got ir=%h v=%b req=%b exp 0abc 1 0", ir_out, ir_valid, mem_req); end
  endtask

  initial begin
    reset = 1'b0; fetch_start = 1'b0; flush = 1'b0; pc_in = '0;
    mem_rdata = '0; mem_ack = 1'b0;
    tick();
    tick();
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_misaligned();
    test_timeout();
    test_flush();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
